// File: rtl/lemming_pkg.sv
// lemming_pkg -- shared state encoding and counter width for the lemming world.
`default_nettype none

package lemming_pkg;

  localparam int FALL_CNT_W = 8;

  typedef enum logic [0:0] {
    W_GROUNDED = 1'b0,
    W_FALLING  = 1'b1
  } world_state_t;

endpackage

`default_nettype wire

// File: rtl/lemming_proto_chk.sv
// lemming_proto_chk -- sticky checker of the lemming's walk/aaah handshake.
// Built only when LEMMING_WORLD_PROTO_CHK_EN is defined.
`default_nettype none

module lemming_proto_chk
  import lemming_pkg::*;
(
  input  logic         clk,
  input  logic         areset,
  input  logic         i_walk_left,
  input  logic         i_walk_right,
  input  logic         i_aaah,
  input  world_state_t i_state,
  input  logic         i_ground,
  input  logic         i_landed,
  output logic         o_proto_err
);

  logic r_proto_err;
  logic w_onehot;
  logic w_violation;

  // Odd parity rules out 0 and 2 set bits; the AND term rules out all three.
  assign w_onehot = (i_walk_left ^ i_walk_right ^ i_aaah) &&
                    !(i_walk_left && i_walk_right && i_aaah);

  // A grounded lemming may scream only while it is losing the ground or just after landing.
  assign w_violation = !w_onehot ||
                       ((i_state == W_FALLING) && !i_aaah) ||
                       ((i_state == W_GROUNDED) && i_aaah && i_ground && !i_landed);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_proto_err <= 1'b0;
    end else if (w_violation) begin
      r_proto_err <= 1'b1;
    end
  end

  assign o_proto_err = r_proto_err;

endmodule

`default_nettype wire

// File: rtl/lemming_world.sv
// lemming_world -- 1-D track world for a walking lemming: walls, holes, falls.
// Optional protocol checker enabled by LEMMING_WORLD_PROTO_CHK_EN.
`default_nettype none

module lemming_world
  import lemming_pkg::*;
#(
  parameter int TRACK_LEN  = 16,
  parameter int START_POS  = 8,
  parameter int FALL_DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic                         i_map_wr,
  input  logic [TRACK_LEN-1:0]         i_map_data,
  input  logic                         i_walk_left,
  input  logic                         i_walk_right,
  input  logic                         i_aaah,
  output logic                         o_bump_left,
  output logic                         o_bump_right,
  output logic                         o_ground,
  output logic [$clog2(TRACK_LEN)-1:0] o_pos,
  output logic                         o_landed,
  output logic                         o_proto_err
);

  localparam int POS_W = $clog2(TRACK_LEN);

  localparam logic [POS_W-1:0]      c_pos_max   = POS_W'(TRACK_LEN - 1);
  localparam logic [POS_W-1:0]      c_pos_start = POS_W'(START_POS);
  localparam logic [POS_W-1:0]      c_pos_one   = POS_W'(1);
  localparam logic [FALL_CNT_W-1:0] c_fall_last = FALL_CNT_W'(FALL_DEPTH - 1);
  localparam logic [FALL_CNT_W-1:0] c_fall_one  = FALL_CNT_W'(1);

  world_state_t          r_state;
  logic [POS_W-1:0]      r_pos;
  logic [FALL_CNT_W-1:0] r_fall_cnt;
  logic [TRACK_LEN-1:0]  r_hole_map;
  logic                  r_landed;

  logic w_hole_here;
  logic w_ground;
  logic w_step_left;
  logic w_step_right;
  logic w_land;

  assign w_hole_here  = r_hole_map[r_pos];
  assign w_ground     = (r_state == W_GROUNDED) && !w_hole_here;
  assign w_step_left  = w_ground && i_walk_left && !i_walk_right && !i_aaah;
  assign w_step_right = w_ground && i_walk_right && !i_walk_left && !i_aaah;
  assign w_land       = (r_state == W_FALLING) && (r_fall_cnt == c_fall_last);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state    <= W_GROUNDED;
      r_pos      <= c_pos_start;
      r_fall_cnt <= '0;
      r_hole_map <= '0;
      r_landed   <= 1'b0;
    end else begin
      r_landed <= w_land;

      case (r_state)
        W_GROUNDED: begin
          if (w_hole_here) begin
            r_state    <= W_FALLING;
            r_fall_cnt <= '0;
          end else if (w_step_left && (r_pos != '0)) begin
            r_pos <= r_pos - c_pos_one;
          end else if (w_step_right && (r_pos != c_pos_max)) begin
            r_pos <= r_pos + c_pos_one;
          end
        end
        W_FALLING: begin
          r_fall_cnt <= r_fall_cnt + c_fall_one;
          if (w_land) begin
            r_state <= W_GROUNDED;
          end
        end
        default: r_state <= W_GROUNDED;
      endcase

      // A fresh map load wins over filling the hole the lemming just landed in.
      if (i_map_wr) begin
        r_hole_map <= i_map_data;
      end else if (w_land) begin
        r_hole_map[r_pos] <= 1'b0;
      end
    end
  end

  assign o_ground     = w_ground;
  assign o_bump_left  = w_ground && i_walk_left && (r_pos == '0);
  assign o_bump_right = w_ground && i_walk_right && (r_pos == c_pos_max);
  assign o_pos        = r_pos;
  assign o_landed     = r_landed;

`ifdef LEMMING_WORLD_PROTO_CHK_EN
  lemming_proto_chk u_proto_chk (
    .clk          (clk),
    .areset       (areset),
    .i_walk_left  (i_walk_left),
    .i_walk_right (i_walk_right),
    .i_aaah       (i_aaah),
    .i_state      (r_state),
    .i_ground     (w_ground),
    .i_landed     (r_landed),
    .o_proto_err  (o_proto_err)
  );
`else
  assign o_proto_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/lemming_world.md
LEMMING_WORLD -- requirements
Module: lemming_world

Interface
REQ-001 Parameter TRACK_LEN, default 16, number of track cells; legal range 4..64.
REQ-002 Parameter START_POS, default 8, cell occupied after reset; legal range 0..TRACK_LEN-1.
REQ-003 Parameter FALL_DEPTH, default 3, cycles spent in W_FALLING per fall; legal range 1..255.
REQ-004 clk  input  1  clock, rising-edge.
REQ-005 areset  input  1  reset, asynchronous, active-high.
REQ-006 map_wr  input  1  load strobe for hole map.
REQ-007 map_data  input  TRACK_LEN  hole map to load; bit i=1 means hole at cell i.
REQ-008 walk_left  input  1  from lemming: walking left.
REQ-009 walk_right  input  1  from lemming: walking right.
REQ-010 aaah  input  1  from lemming: falling.
REQ-011 bump_left  output  1  to lemming: left wall hit.
REQ-012 bump_right  output  1  to lemming: right wall hit.
REQ-013 ground  output  1  to lemming: ground present.
REQ-014 pos  output  clog2(TRACK_LEN)  current cell.
REQ-015 landed  output  1  one-cycle pulse after each landing.
REQ-016 proto_err  output  1  sticky lemming-protocol error.

Function
REQ-017 State machine: W_GROUNDED, W_FALLING; 8-bit fall_cnt; TRACK_LEN-bit hole_map.
REQ-018 Outputs:
- ground = (state==W_GROUNDED) && !hole_map[pos], combinational.
- bump_left = ground && walk_left && pos==0.
- bump_right = ground && walk_right && pos==TRACK_LEN-1.
REQ-019 Movement, W_GROUNDED only, when ground=1 and exactly one of walk_left/walk_right is high with aaah low:
- walk_left: pos decrements, saturating at 0.
- walk_right: pos increments, saturating at TRACK_LEN-1.
- Any other input combination: pos holds.
REQ-020 W_GROUNDED with hole_map[pos]=1: pos holds; next state W_FALLING; fall_cnt<=0.
REQ-021 W_FALLING: fall_cnt increments each cycle, inputs ignored for movement. When fall_cnt==FALL_DEPTH-1, next state is W_GROUNDED and hole_map[pos]<=0 (hole filled). ground is therefore low for exactly FALL_DEPTH+1 cycles per fall.
REQ-022 landed is registered: high for exactly the first cycle after W_FALLING->W_GROUNDED.
REQ-023 map_wr=1 loads hole_map<=map_data in any state. It takes priority over the landing clear in the same cycle; pos and state are unaffected.

Reset
REQ-024 areset forces immediately, mid-fall included: state=W_GROUNDED, pos=START_POS, hole_map=0, fall_cnt=0, landed=0, proto_err=0.
REQ-025 Output values during reset: ground=1, bump_left=bump_right=0 until first inputs.

Configuration
REQ-026 Macro LEMMING_WORLD_PROTO_CHK_EN defined: proto_err sets, sticky until areset, when any of the following holds at a rising edge:
- {walk_left,walk_right,aaah} is not one-hot;
- aaah=0 while state=W_FALLING;
- aaah=1 while state=W_GROUNDED, except the first cycle after landing and the cycle in which ground=0 first appears.
REQ-027 Macro undefined: proto_err port is still present and tied to 0; no checker logic is built.

Structure
REQ-028 Package lemming_pkg holds world_state_t {W_GROUNDED, W_FALLING} and the FALL_CNT_W=8 constant.
REQ-029 Sub-module lemming_proto_chk holds the REQ-026 checker and is instantiated only under the macro.

Verification (TRACK_LEN=16, START_POS=8, FALL_DEPTH=3)
REQ-030 Reset, map 0, walk_left held -> pos 8->0 in 8 cycles; afterwards bump_left=1 and pos stays 0.
REQ-031 map_data=16'h0010 loaded, walk_left held -> on reaching pos 4: ground=0 for 4 cycles, then landed=1 for 1 cycle, hole_map[4]=0, pos=4, then walking resumes.
REQ-032 areset pulse during W_FALLING -> same cycle: ground=1, pos=8, hole_map=0, landed=0.
REQ-033 walk_left=walk_right=1 at pos 5 -> pos holds 5; with macro, proto_err=1 and stays 1 until areset.
REQ-034 map_wr with map_data bit 4=1 on the landing cycle at pos 4 -> hole_map[4] stays 1; the next cycle ground=0 and a second fall starts.
REQ-035 walk_right held from pos 8, map 0 -> pos saturates at 15 after 7 cycles; bump_right=1 while walk_right=1.
